// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions, serializer state encoding and frame geometry.
package mmio_uart_pkg;

  localparam logic [3:0] OFF_TXDATA  = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_DIVISOR = 4'h8;

  localparam int STAT_OVERFLOW = 0;
  localparam int STAT_FULL     = 1;
  localparam int STAT_EMPTY    = 2;
  localparam int STAT_BUSY     = 3;

  localparam int FRAME_BITS = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a combinational head.
// Pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             empty_q;
  logic             push_ok;
  logic             pop_ok;

  // Full is judged on the registered flag, so a push+pop while full still drops the push.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the CPU data port: TXDATA stores feed a
// FIFO, a divisor-timed serializer drains it onto txd; reads are combinational.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] CLK_DIV    = 16'd868
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        d_ram_rena,
  input  logic        d_ram_wena,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  output logic [31:0] Data_out,
  output logic        txd,
  output logic        tx_empty
);

  localparam int BIT_W = $clog2(FRAME_BITS);

  logic                        hit;
  logic [3:0]                  offset;
  logic                        wr_txdata;
  logic                        wr_status;
  logic                        wr_divisor;
  logic                        overflow_q;
  logic [15:0]                 divisor_q;
  logic [31:0]                 status_word;

  logic                        fifo_pop;
  logic [7:0]                  fifo_dout;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  tx_state_e                   state_q, state_d;
  logic [15:0]                 baud_q, baud_d;
  logic [BIT_W-1:0]            bit_q, bit_d;
  logic [7:0]                  shift_q, shift_d;
  logic [15:0]                 div_q, div_d;
  logic                        txd_q, txd_d;
  logic                        baud_done;
  logic                        busy;
  logic                        unused_bits;

  assign hit        = (DAddr[31:4] == BASE_ADDR[31:4]);
  assign offset     = {DAddr[3:2], 2'b00};
  assign wr_txdata  = hit && d_ram_wena && (offset == OFF_TXDATA);
  assign wr_status  = hit && d_ram_wena && (offset == OFF_STATUS);
  assign wr_divisor = hit && d_ram_wena && (offset == OFF_DIVISOR);

  assign unused_bits = ^{DAddr[1:0], DataIn[31:16], fifo_count};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (DataIn[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk_in) begin
    if (reset) begin
      overflow_q <= 1'b0;
      divisor_q  <= CLK_DIV;
    end else begin
      if (wr_txdata && fifo_full) begin
        overflow_q <= 1'b1;
      end else if (wr_status && DataIn[STAT_OVERFLOW]) begin
        overflow_q <= 1'b0;
      end
      if (wr_divisor) divisor_q <= DataIn[15:0];
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign tx_empty = fifo_empty && !busy;

  always_comb begin
    status_word                = '0;
    status_word[STAT_OVERFLOW] = overflow_q;
    status_word[STAT_FULL]     = fifo_full;
    status_word[STAT_EMPTY]    = fifo_empty;
    status_word[STAT_BUSY]     = busy;
  end

  // Read data reflects pre-edge state, so a same-cycle write is not visible yet.
  always_comb begin
    Data_out = '0;
    if (hit && d_ram_rena) begin
      case (offset)
        OFF_STATUS:  Data_out = status_word;
        OFF_DIVISOR: Data_out = {16'h0000, divisor_q};
        default:     Data_out = '0;
      endcase
    end
  end

  assign baud_done = (baud_q == div_q - 16'd1);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    div_d    = div_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          div_d    = (divisor_q == 16'd0) ? 16'd1 : divisor_q;
          baud_d   = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // txd is registered from the next state so the line changes on the same edge as the FSM.
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      txd_q   <= txd_d;
    end
  end

  always_ff @(posedge clk_in) begin
    shift_q <= shift_d;
    div_q   <= div_d;
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register table, hand sequences for frame timing, overflow,
// divisor changes and reset, plus random traffic against a frame-schedule model.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 8;
  localparam logic [15:0] DIV0  = 16'd4;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic        rena   = 1'b0;
  logic        wena   = 1'b0;
  logic [31:0] addr   = '0;
  logic [31:0] wdata  = '0;
  logic [31:0] dout;
  logic        txd;
  logic        tx_empty;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .CLK_DIV    (DIV0)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .d_ram_rena (rena),
    .d_ram_wena (wena),
    .DAddr      (addr),
    .DataIn     (wdata),
    .Data_out   (dout),
    .txd        (txd),
    .tx_empty   (tx_empty)
  );

  // Reference model: each accepted byte becomes a frame with a push edge, a start
  // edge and a bit period; line state and flags are derived from that schedule.
  typedef struct {
    int         push;
    int         s;
    int         d;
    logic [7:0] b;
  } frame_t;

  frame_t      frames[$];
  logic [15:0] m_div = DIV0;
  logic        m_ovf = 1'b0;

  function automatic int eff(logic [15:0] v);
    return (v == 16'd0) ? 1 : int'(v);
  endfunction

  function automatic bit hit_of(logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic int pending(int t);
    int n = 0;
    foreach (frames[i]) if (frames[i].push <= t && frames[i].s > t) n++;
    return n;
  endfunction

  function automatic bit busy_at(int t);
    foreach (frames[i]) if (frames[i].s <= t && t < frames[i].s + 10 * frames[i].d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_txd(int t);
    foreach (frames[i]) begin
      if (frames[i].s <= t && t < frames[i].s + 10 * frames[i].d) begin
        int slot = (t - frames[i].s) / frames[i].d;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return frames[i].b[slot-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_empty(int t);
    return (pending(t) == 0) && !busy_at(t);
  endfunction

  function automatic int model_end();
    int e = 0;
    foreach (frames[i]) if (frames[i].s + 10 * frames[i].d > e) e = frames[i].s + 10 * frames[i].d;
    return e;
  endfunction

  function automatic logic [31:0] model_read(bit re, logic [31:0] a, int t);
    if (!re || !hit_of(a)) return 32'h0;
    case (a[3:2])
      2'd1: return {28'h0, busy_at(t), pending(t) == 0, pending(t) == DEPTH, m_ovf};
      2'd2: return {16'h0, m_div};
      default: return 32'h0;
    endcase
  endfunction

  // A divisor written on edge w applies to every frame that starts after w.
  function automatic void recompute(int w);
    for (int i = 0; i < frames.size(); i++) begin
      frame_t f = frames[i];
      if (f.s > w) begin
        int st = f.push + 1;
        f.d = eff(m_div);
        if (i > 0 && frames[i-1].s + 10 * frames[i-1].d + 1 > st)
          st = frames[i-1].s + 10 * frames[i-1].d + 1;
        f.s = st;
        frames[i] = f;
      end
    end
  endfunction

  function automatic void model_write(logic [31:0] a, logic [31:0] d, int e);
    if (!hit_of(a)) return;
    case (a[3:2])
      2'd0: begin
        int n = 0;
        foreach (frames[i]) if (frames[i].s >= e) n++;
        if (n >= DEPTH) begin
          m_ovf = 1'b1;
        end else begin
          frame_t f;
          f.push = e;
          f.b    = d[7:0];
          f.d    = eff(m_div);
          f.s    = e + 1;
          if (frames.size() > 0) begin
            frame_t l = frames[frames.size()-1];
            if (l.s + 10 * l.d + 1 > f.s) f.s = l.s + 10 * l.d + 1;
          end
          frames.push_back(f);
        end
      end
      2'd1: if (d[0]) m_ovf = 1'b0;
      2'd2: begin
        m_div = d[15:0];
        recompute(e);
      end
      default: ;
    endcase
  endfunction

  function automatic void model_reset();
    frames.delete();
    m_div = DIV0;
    m_ovf = 1'b0;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic bus_op(input bit re, input bit we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
    rena  = re;
    wena  = we;
    addr  = a;
    wdata = d;
    #1;
    rd = dout;
    if (we) begin
      @(posedge clk_in);
      #1;
      model_write(a, d, cyc);
    end
    rena  = 1'b0;
    wena  = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    bus_op(1'b0, 1'b1, a, d, unused_rd);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_op(1'b1, 1'b0, a, 32'h0, v);
    check(nm, v, exp);
  endtask

  task automatic rd_model(input string nm, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] e;
    e = model_read(1'b1, a, cyc);
    bus_op(1'b1, 1'b0, a, 32'h0, v);
    check(nm, v, e);
  endtask

  // Line and tx_empty are logged on the falling edge; entry i belongs to edge log_base+i.
  bit   log_en = 1'b0;
  int   log_base = 0;
  logic txd_log[$];
  logic emp_log[$];

  always @(negedge clk_in) begin
    if (log_en) begin
      txd_log.push_back(txd);
      emp_log.push_back(tx_empty);
    end
  end

  task automatic start_log();
    txd_log.delete();
    emp_log.delete();
    log_base = cyc;
    log_en   = 1'b1;
  endtask

  task automatic check_log(input string nm);
    int nbad = 0;
    int first = -1;
    log_en = 1'b0;
    foreach (txd_log[i]) begin
      if (txd_log[i] !== exp_txd(log_base + i) || emp_log[i] !== exp_empty(log_base + i)) begin
        nbad++;
        if (first < 0) first = i;
      end
    end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL %s: %0d of %0d cycles differ, first at +%0d txd=%b required %b tx_empty=%b required %b",
               nm, nbad, txd_log.size(), first, txd_log[first], exp_txd(log_base + first),
               emp_log[first], exp_empty(log_base + first));
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    int tend = model_end();
    while (cyc < tend + 3 && n < budget) begin
      tick(1);
      n++;
    end
    if (cyc < tend + 3) begin
      total++;
      bad++;
      $display("FAIL %s: wait budget of %0d cycles expired", nm, budget);
    end
    check({nm, "_tx_empty"}, tx_empty, 1);
  endtask

  typedef struct {
    bit          re;
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[$];

  task automatic addv(input bit re, input bit we, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp);
    vec_t v;
    v.re = re; v.we = we; v.a = a; v.d = d; v.exp = exp;
    vt.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int          s0;

    repeat (3) @(posedge clk_in);
    #1;
    reset = 1'b0;
    model_reset();
    check("reset_txd", txd, 1);
    check("reset_tx_empty", tx_empty, 1);

    addv(1, 0, BASE + 32'h0, 32'h0, 32'h0);
    addv(1, 0, BASE + 32'h4, 32'h0, 32'h4);
    addv(1, 0, BASE + 32'h8, 32'h0, 32'h4);
    addv(1, 0, BASE + 32'hC, 32'h0, 32'h0);
    addv(1, 1, BASE + 32'h8, 32'h1234_0002, 32'h4);
    addv(1, 0, BASE + 32'h8, 32'h0, 32'h2);
    addv(1, 0, BASE + 32'hA, 32'h0, 32'h2);
    addv(1, 1, BASE + 32'hC, 32'hFFFF_FFFF, 32'h0);
    addv(1, 0, BASE + 32'hC, 32'h0, 32'h0);
    addv(1, 0, BASE + 32'h18, 32'h0, 32'h0);
    addv(0, 0, BASE + 32'h8, 32'h0, 32'h0);
    addv(0, 1, BASE + 32'h8, 32'h4, 32'h0);
    addv(1, 0, BASE + 32'h8, 32'h0, 32'h4);
    addv(1, 1, BASE + 32'h10, 32'hA5, 32'h0);
    addv(1, 1, BASE + 32'h4, 32'h1, 32'h4);
    addv(1, 0, BASE + 32'h4, 32'h0, 32'h4);
    addv(1, 0, BASE + 32'h14, 32'h0, 32'h0);

    start_log();
    foreach (vt[i]) begin
      bus_op(vt[i].re, vt[i].we, vt[i].a, vt[i].d, v);
      check($sformatf("vec%0d", i), v, vt[i].exp);
    end
    tick(6);
    check_log("table_idle_line");

    // Single 0xA5 frame at 4 cycles per bit: exact latency and tx_empty timing.
    start_log();
    wr(BASE + 32'h0, 32'h0000_00A5);
    check("a_txd_on_store_edge", txd, 1);
    tick(1);
    check("a_start_bit", txd, 0);
    tick(39);
    check("a_tx_empty_cycle39", tx_empty, 0);
    tick(1);
    check("a_tx_empty_cycle40", tx_empty, 1);
    tick(3);
    check_log("a_frame_a5");

    // Divisor 2, then 0 (treated as 1).
    wr(BASE + 32'h8, 32'h0000_0002);
    rd_chk("b_div_readback", BASE + 32'h8, 32'h0000_0002);
    start_log();
    wr(BASE + 32'h0, 32'h3C);
    wait_idle(200, "b_div2_idle");
    wr(BASE + 32'h8, 32'h0000_0000);
    rd_chk("b_div0_readback", BASE + 32'h8, 32'h0000_0000);
    wr(BASE + 32'h0, 32'hC3);
    wait_idle(200, "b_div0_idle");
    check_log("b_div2_div0_frames");
    wr(BASE + 32'h8, 32'h4);

    // Ten back-to-back stores: one goes straight to the serializer, eight fill the FIFO.
    start_log();
    for (int i = 0; i < 10; i++) wr(BASE + 32'h0, 32'(8'h10 + i));
    rd_chk("c_status_overflow_full", BASE + 32'h4, 32'hB);
    wr(BASE + 32'h4, 32'h1);
    rd_chk("c_status_cleared", BASE + 32'h4, 32'hA);
    wait_idle(1000, "c_nine_idle");
    check_log("c_nine_frames");
    check("c_model_frame_count", 32'(frames.size()), 32'd12);

    // Divisor change during a frame only affects the next frame.
    start_log();
    wr(BASE + 32'h0, 32'h5A);
    wr(BASE + 32'h0, 32'h96);
    tick(8);
    wr(BASE + 32'h8, 32'h8);
    check("d_first_frame_busy", tx_empty, 0);
    wait_idle(500, "d_idle");
    check_log("d_div_midframe");
    rd_chk("d_div_readback", BASE + 32'h8, 32'h8);

    // Random traffic against the schedule model.
    wr(BASE + 32'h8, 32'($urandom_range(1, 3)));
    start_log();
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 35) begin
        wr(BASE + 32'h0, $urandom);
      end else if (r < 47) begin
        rd_model("rand_status", BASE + 32'h4);
      end else if (r < 50) begin
        wr(BASE + 32'h8, 32'($urandom_range(0, 3)));
      end else if (r < 54) begin
        wr(BASE + 32'h4, $urandom);
      end else if (r < 58) begin
        rd_model("rand_read", BASE + {26'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))});
      end else begin
        tick(1);
      end
    end
    wait_idle(3000, "rand_idle");
    check_log("rand_wave");

    // Reset during data bit 3 of 0x07 (bit 3 is 0) with more bytes queued.
    wr(BASE + 32'h8, 32'h4);
    start_log();
    wr(BASE + 32'h0, 32'h07);
    s0 = cyc + 1;
    wr(BASE + 32'h0, 32'h11);
    wr(BASE + 32'h0, 32'h22);
    wr(BASE + 32'h0, 32'h33);
    while (cyc < s0 + 17) tick(1);
    check("e_txd_bit3_before_reset", txd, 0);
    check_log("e_pre_reset");
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    check("e_txd_after_reset", txd, 1);
    reset = 1'b0;
    model_reset();
    rd_chk("e_status_after_reset", BASE + 32'h4, 32'h4);
    rd_chk("e_div_after_reset", BASE + 32'h8, 32'h4);
    start_log();
    tick(120);
    check_log("e_no_frames_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
